// File: rtl/fir_decim_scaler.sv
// Decimating averager behind the 16-tap FIR: frame sum, round, shift, saturate.
// Result is held in a valid/ready output register; sticky clip and overrun flags.
module fir_decim_scaler #(
    parameter int IN_WIDTH  = 30,
    parameter int OUT_WIDTH = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        en,
    input  logic signed [IN_WIDTH-1:0]  din,
    input  logic [CNT_WIDTH-1:0]        decim,
    input  logic [4:0]                  shift,
    input  logic                        clr_flags,
    output logic signed [OUT_WIDTH-1:0] dout,
    output logic                        dout_valid,
    input  logic                        dout_ready,
    output logic                        sat_flag,
    output logic                        ovr_flag
);

    localparam int AW = IN_WIDTH + CNT_WIDTH;

    localparam logic [CNT_WIDTH-1:0] C_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [AW:0] R_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic signed [AW:0] S_MAX =
        {{(AW-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [AW:0] S_MIN =
        {{(AW-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] r_r_lat;
    logic [4:0]           r_sh_lat;
    logic signed [AW-1:0] r_acc;

    logic                 r_a_vld;
    logic signed [AW-1:0] r_a_sum;
    logic [4:0]           r_a_sh;

    logic [CNT_WIDTH-1:0]  w_decim_eff;
    logic [CNT_WIDTH-1:0]  w_r_cur;
    logic [4:0]            w_sh_cur;
    logic                  w_first;
    logic                  w_last;
    logic signed [AW-1:0]  w_din_x;
    logic signed [AW-1:0]  w_sum;
    logic [AW:0]           w_half;
    logic signed [AW:0]    w_rnd;
    logic signed [AW:0]    w_shr;
    logic                  w_hi;
    logic                  w_lo;
    logic [OUT_WIDTH-1:0]  w_res;
    logic                  w_load;
    logic                  w_drop;

    // At the first sample of a frame the live decim/shift apply, so R=1 closes at once
    assign w_first     = (r_cnt == '0);
    assign w_decim_eff = (decim == '0) ? C_ONE : decim;
    assign w_r_cur     = w_first ? w_decim_eff : r_r_lat;
    assign w_sh_cur    = w_first ? shift : r_sh_lat;
    assign w_last      = (r_cnt == w_r_cur - C_ONE);
    assign w_din_x     = {{CNT_WIDTH{din[IN_WIDTH-1]}}, din};
    assign w_sum       = w_first ? w_din_x : r_acc + w_din_x;

    assign w_half = (r_a_sh == 5'd0) ? '0 : (R_ONE << (r_a_sh - 5'd1));
    assign w_rnd  = {r_a_sum[AW-1], r_a_sum} + w_half;
    assign w_shr  = w_rnd >>> r_a_sh;
    assign w_hi   = (w_shr > S_MAX);
    assign w_lo   = (w_shr < S_MIN);
    assign w_res  = w_hi ? S_MAX[OUT_WIDTH-1:0] :
                    w_lo ? S_MIN[OUT_WIDTH-1:0] : w_shr[OUT_WIDTH-1:0];

    assign w_load = r_a_vld & (~dout_valid | dout_ready);
    assign w_drop = r_a_vld & dout_valid & ~dout_ready;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cnt    <= '0;
            r_r_lat  <= C_ONE;
            r_sh_lat <= '0;
            r_acc    <= '0;
            r_a_vld  <= 1'b0;
            r_a_sum  <= '0;
            r_a_sh   <= '0;
        end else if (!en) begin
            r_cnt   <= '0;
            r_acc   <= '0;
            r_a_vld <= 1'b0;
        end else begin
            if (w_first) begin
                r_r_lat  <= w_decim_eff;
                r_sh_lat <= shift;
            end
            if (w_last) begin
                r_cnt   <= '0;
                r_acc   <= '0;
                r_a_vld <= 1'b1;
                r_a_sum <= w_sum;
                r_a_sh  <= w_sh_cur;
            end else begin
                r_cnt   <= r_cnt + C_ONE;
                r_acc   <= w_sum;
                r_a_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            sat_flag   <= 1'b0;
            ovr_flag   <= 1'b0;
        end else begin
            if (w_load) begin
                dout       <= w_res;
                dout_valid <= 1'b1;
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end
            // A set event on the same edge overrides the clear
            if (w_load && (w_hi || w_lo)) begin
                sat_flag <= 1'b1;
            end else if (clr_flags) begin
                sat_flag <= 1'b0;
            end
            if (w_drop) begin
                ovr_flag <= 1'b1;
            end else if (clr_flags) begin
                ovr_flag <= 1'b0;
            end
        end
    end

endmodule
